// File: rtl/draw_pkg.sv
// Shared constants and state encoding for the VGA draw scheduler.
package draw_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    localparam logic [2:0] COLOUR_BLACK = 3'b000;
    localparam logic [2:0] COLOUR_WHITE = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ERASE = 2'd1,
        ST_DRAW  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/draw_scheduler_rr_arbiter.sv
// Round-robin arbiter: the search starts one past the last grant and the first
// set request wins.
module rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last_grant,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_grant_idx,
    output logic               o_valid
);

    logic [IDX_W-1:0] w_cand;

    // NOTE: every output of a combinational block gets a default first, so
    // no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        o_valid     = 1'b0;
        w_cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = IDX_W'((int'(i_last_grant) + k) % NUM_REQ);
            if (!o_valid && i_req[w_cand]) begin
                o_valid     = 1'b1;
                o_grant_idx = w_cand;
            end
        end
        o_grant[o_grant_idx] = o_valid;
    end

endmodule

// File: rtl/draw_scheduler.sv
// Shares the VGA plot port between sprite engines. It walks one granted rectangle
// per pixel per clock. Define DRAW_SCHED_ERASE_EN to erase each requester's previous rectangle first.
module draw_scheduler
    import draw_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int DIM_W   = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*8-1:0]     req_x,
    input  logic [NUM_REQ*7-1:0]     req_y,
    input  logic [NUM_REQ*DIM_W-1:0] req_w,
    input  logic [NUM_REQ*DIM_W-1:0] req_h,
    input  logic [NUM_REQ*3-1:0]     req_colour,
    output logic [NUM_REQ-1:0]       done,
    output logic [7:0]               plot_x,
    output logic [6:0]               plot_y,
    output logic [2:0]               plot_colour,
    output logic                     plot_en,
    output logic                     busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t               r_state, w_next_state;
    logic [IDX_W-1:0]     r_last_grant, r_idx;
    logic [NUM_REQ-1:0]   r_grant_oh;
    logic [7:0]           r_x;
    logic [6:0]           r_y;
    logic [DIM_W-1:0]     r_w, r_h, r_cx, r_cy;
    logic [2:0]           r_colour;

    logic [NUM_REQ-1:0]   w_grant;
    logic [IDX_W-1:0]     w_gidx;
    logic                 w_arb_valid;
    logic [DIM_W-1:0]     w_req_w, w_req_h;
    logic                 w_grant_empty;

    logic [7:0]           w_walk_x;
    logic [6:0]           w_walk_y;
    logic [DIM_W-1:0]     w_walk_w, w_walk_h;
    logic [2:0]           w_walk_colour;
    logic [8:0]           w_sum_x;
    logic [7:0]           w_sum_y;
    logic                 w_walking, w_row_end, w_last_px;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
        .i_req        (req),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant),
        .o_grant_idx  (w_gidx),
        .o_valid      (w_arb_valid)
    );

    assign w_req_w       = req_w[DIM_W*w_gidx +: DIM_W];
    assign w_req_h       = req_h[DIM_W*w_gidx +: DIM_W];
    assign w_grant_empty = (w_req_w == '0) || (w_req_h == '0);

`ifdef DRAW_SCHED_ERASE_EN
    // NOTE: only the valid bits are reset; the stored geometry is never read
    // while its valid bit is clear, so the arrays need no reset.
    logic [7:0]       r_prev_x [NUM_REQ];
    logic [6:0]       r_prev_y [NUM_REQ];
    logic [DIM_W-1:0] r_prev_w [NUM_REQ];
    logic [DIM_W-1:0] r_prev_h [NUM_REQ];
    logic [NUM_REQ-1:0] r_prev_valid;
    logic             w_erase_needed;

    assign w_erase_needed = r_prev_valid[w_gidx] && (r_prev_w[w_gidx] != '0)
                            && (r_prev_h[w_gidx] != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev_valid <= '0;
        end else if (r_state == ST_DONE) begin
            r_prev_valid[r_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == ST_DONE) begin
            r_prev_x[r_idx] <= r_x;
            r_prev_y[r_idx] <= r_y;
            r_prev_w[r_idx] <= r_w;
            r_prev_h[r_idx] <= r_h;
        end
    end
`endif

    // The scanner walks either the stored old rectangle (in black) or the new one.
    always_comb begin
        w_walk_x      = r_x;
        w_walk_y      = r_y;
        w_walk_w      = r_w;
        w_walk_h      = r_h;
        w_walk_colour = r_colour;
`ifdef DRAW_SCHED_ERASE_EN
        if (r_state == ST_ERASE) begin
            w_walk_x      = r_prev_x[r_idx];
            w_walk_y      = r_prev_y[r_idx];
            w_walk_w      = r_prev_w[r_idx];
            w_walk_h      = r_prev_h[r_idx];
            w_walk_colour = COLOUR_BLACK;
        end
`endif
    end

    assign w_walking = (r_state == ST_DRAW) || (r_state == ST_ERASE);
    assign w_sum_x   = {1'b0, w_walk_x} + 9'(r_cx);
    assign w_sum_y   = {1'b0, w_walk_y} + 8'(r_cy);
    assign w_row_end = (r_cx == w_walk_w - DIM_W'(1));
    assign w_last_px = w_row_end && (r_cy == w_walk_h - DIM_W'(1));

    assign plot_en     = w_walking && (w_sum_x < 9'(SCREEN_W)) && (w_sum_y < 8'(SCREEN_H));
    assign plot_x      = w_walking ? w_sum_x[7:0] : '0;
    assign plot_y      = w_walking ? w_sum_y[6:0] : '0;
    assign plot_colour = w_walking ? w_walk_colour : '0;
    assign done        = (r_state == ST_DONE) ? r_grant_oh : '0;
    assign busy        = (r_state != ST_IDLE);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_arb_valid) begin
                    w_next_state = w_grant_empty ? ST_DONE : ST_DRAW;
`ifdef DRAW_SCHED_ERASE_EN
                    if (w_erase_needed) w_next_state = ST_ERASE;
`endif
                end
            end
`ifdef DRAW_SCHED_ERASE_EN
            ST_ERASE: begin
                if (w_last_px)
                    w_next_state = ((r_w == '0) || (r_h == '0)) ? ST_DONE : ST_DRAW;
            end
`endif
            ST_DRAW: if (w_last_px) w_next_state = ST_DONE;
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_last_grant <= IDX_W'(NUM_REQ - 1);
            r_idx        <= '0;
            r_grant_oh   <= '0;
            r_x          <= '0;
            r_y          <= '0;
            r_w          <= '0;
            r_h          <= '0;
            r_colour     <= '0;
            r_cx         <= '0;
            r_cy         <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == ST_IDLE && w_arb_valid) begin
                r_idx      <= w_gidx;
                r_grant_oh <= w_grant;
                r_x        <= req_x[8*w_gidx +: 8];
                r_y        <= req_y[7*w_gidx +: 7];
                r_w        <= w_req_w;
                r_h        <= w_req_h;
                r_colour   <= req_colour[3*w_gidx +: 3];
            end
            if (w_walking) begin
                if (w_last_px) begin
                    r_cx <= '0;
                    r_cy <= '0;
                end else if (w_row_end) begin
                    r_cx <= '0;
                    r_cy <= r_cy + DIM_W'(1);
                end else begin
                    r_cx <= r_cx + DIM_W'(1);
                end
            end
            if (r_state == ST_DONE) r_last_grant <= r_idx;
        end
    end

endmodule
